// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, defaults and
// the data-phase record carried from grant edge to data cycle.
package sram_arb_pkg;

    localparam int DEF_AW    = 10;
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 1024;
    localparam int ID_W      = 2;
    localparam int DW_MAX    = 32;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_DRAIN,
        ST_ARB
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ID_W-1:0]   id;
        logic [DW_MAX-1:0] wdata;
    } dp_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin winner select with registered rotating pointer and an
// optional lock that keeps re-granting the same requester.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            I_HCLK,
    input  logic            I_HRESETn,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] gnt,
    output logic            hit,
    output logic [ID_W-1:0] win
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] lock_id_q;
    logic            locked_q;
    logic            found;

    always_comb begin
        found = 1'b0;
        win   = '0;
        if (locked_q && req[lock_id_q]) begin
            found = 1'b1;
            win   = lock_id_q;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                    found = 1'b1;
                    win   = ID_W'((int'(ptr_q) + i) % NREQ);
                end
            end
        end
        hit = en && found;
        gnt = hit ? (NREQ'(1) << win) : '0;
    end

    always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
        if (!I_HRESETn) begin
            ptr_q     <= '0;
            lock_id_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            locked_q <= hit && lock[win];
            if (hit) begin
                lock_id_q <= win;
                ptr_q     <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Zero-fills a single-port SRAM after reset, then shares it round-robin.
// Define SRAM_ARB_LOCK_EN to add the I_LOCK burst-lock input.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               I_HCLK,
    input  logic               I_HRESETn,
    input  logic [NREQ-1:0]    I_REQ,
    input  logic [NREQ-1:0]    I_WR,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]    I_LOCK,
`endif
    input  logic [NREQ*AW-1:0] I_ADDR,
    input  logic [NREQ*DW-1:0] I_WDATA,
    output logic [NREQ-1:0]    O_GNT,
    output logic [NREQ-1:0]    O_RVALID,
    output logic [DW-1:0]      O_RDATA,
    output logic               O_INIT_DONE,
    output logic [AW-1:0]      O_MADDR,
    output logic [DW-1:0]      O_MWDATA,
    output logic               O_MWREN,
    input  logic [DW-1:0]      I_MRDATA
);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   maddr_q;
    logic            done_q;
    dp_t             dp_q, dp_d;
    logic [NREQ-1:0] lock;
    logic            hit;
    logic [ID_W-1:0] win;

`ifdef SRAM_ARB_LOCK_EN
    assign lock = I_LOCK;
`else
    assign lock = '0;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .I_HCLK    (I_HCLK),
        .I_HRESETn (I_HRESETn),
        .en        (state_q == ST_ARB),
        .req       (I_REQ),
        .lock      (lock),
        .gnt       (O_GNT),
        .hit       (hit),
        .win       (win)
    );

    always_comb begin
        state_d = state_q;
        dp_d    = '0;
        O_MADDR = maddr_q;
        unique case (state_q)
            ST_INIT: begin
                O_MADDR    = cnt_q;
                dp_d.valid = 1'b1;
                dp_d.wr    = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_ARB;
            ST_ARB: begin
                if (hit) begin
                    O_MADDR    = I_ADDR[win*AW +: AW];
                    dp_d.valid = 1'b1;
                    dp_d.wr    = I_WR[win];
                    dp_d.id    = win;
                    dp_d.wdata = DW_MAX'(I_WDATA[win*DW +: DW]);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
        if (!I_HRESETn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            maddr_q <= '0;
            done_q  <= 1'b0;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= O_MADDR;
            dp_q    <= dp_d;
            if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_DRAIN) done_q <= 1'b1;
        end
    end

    // The data phase is driven entirely from the record latched at grant.
    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            O_RVALID[n] = dp_q.valid && !dp_q.wr && (dp_q.id == ID_W'(n));
        end
    end

    assign O_MWREN     = dp_q.valid && dp_q.wr;
    assign O_MWDATA    = dp_q.wdata[DW-1:0];
    assign O_RDATA     = I_MRDATA;
    assign O_INIT_DONE = done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  wr = '0;
    logic [9:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, mwdata, mrdata;
    logic        done, mwren;
    logic [9:0]  maddr;
`ifdef SRAM_ARB_LOCK_EN
    logic [1:0]  lock = '0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .I_HCLK      (clk),
        .I_HRESETn   (rst_n),
        .I_REQ       (req),
        .I_WR        (wr),
`ifdef SRAM_ARB_LOCK_EN
        .I_LOCK      (lock),
`endif
        .I_ADDR      ({a1, a0}),
        .I_WDATA     ({d1, d0}),
        .O_GNT       (gnt),
        .O_RVALID    (rvalid),
        .O_RDATA     (rdata),
        .O_INIT_DONE (done),
        .O_MADDR     (maddr),
        .O_MWDATA    (mwdata),
        .O_MWREN     (mwren),
        .I_MRDATA    (mrdata)
    );

    // SRAM: registered address, write data/enable one cycle after address.
    logic [31:0] mem [0:1023];
    logic [9:0]  maq = '0;
    logic        preload = 1'b1;
    assign mrdata = mem[maq];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (mwren) begin
            mem[maq] <= mwdata;
        end
        maq <= maddr;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int edges = 0;
        int gbad = 0;
        while (edges < 2000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
            if (gnt != 2'b00) gbad++;
        end
        chk({tag, " init latency"}, edges, 1025);
        chk({tag, " gnt held 0"}, gbad, 0);
    endtask

    typedef struct {
        logic [1:0]  req, wr;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  gnt, rv;
        logic [31:0] rd;
        logic        wen;
        logic [31:0] wd;
        logic [9:0]  ma;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [1:0] prev;
        vt[0]  = '{2'b01, 2'b01, 10'h005, 10'h000, 32'hDEADBEEF, 32'h0,
                   2'b01, 2'b00, 32'h0, 1'b0, 32'h0, 10'h005};
        vt[1]  = '{2'b01, 2'b00, 10'h005, 10'h000, 32'h0, 32'h0,
                   2'b01, 2'b00, 32'h0, 1'b1, 32'hDEADBEEF, 10'h005};
        vt[2]  = '{2'b01, 2'b01, 10'h3FF, 10'h000, 32'h12345678, 32'h0,
                   2'b01, 2'b01, 32'hDEADBEEF, 1'b0, 32'h0, 10'h3FF};
        vt[3]  = '{2'b11, 2'b00, 10'h3FF, 10'h000, 32'h0, 32'h0,
                   2'b10, 2'b00, 32'h0, 1'b1, 32'h12345678, 10'h000};
        vt[4]  = '{2'b11, 2'b00, 10'h3FF, 10'h001, 32'h0, 32'h0,
                   2'b01, 2'b10, 32'h0, 1'b0, 32'h0, 10'h3FF};
        vt[5]  = '{2'b11, 2'b00, 10'h004, 10'h001, 32'h0, 32'h0,
                   2'b10, 2'b01, 32'h12345678, 1'b0, 32'h0, 10'h001};
        vt[6]  = '{2'b11, 2'b00, 10'h004, 10'h005, 32'h0, 32'h0,
                   2'b01, 2'b10, 32'h0, 1'b0, 32'h0, 10'h004};
        vt[7]  = '{2'b11, 2'b00, 10'h005, 10'h005, 32'h0, 32'h0,
                   2'b10, 2'b01, 32'h0, 1'b0, 32'h0, 10'h005};
        vt[8]  = '{2'b10, 2'b10, 10'h005, 10'h200, 32'h0, 32'hCAFEF00D,
                   2'b10, 2'b10, 32'hDEADBEEF, 1'b0, 32'h0, 10'h200};
        vt[9]  = '{2'b01, 2'b00, 10'h200, 10'h200, 32'h0, 32'h0,
                   2'b01, 2'b00, 32'h0, 1'b1, 32'hCAFEF00D, 10'h200};
        vt[10] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0,
                   2'b00, 2'b01, 32'hCAFEF00D, 1'b0, 32'h0, 10'h200};

        req = 2'b01;
        a0  = 10'h3FF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk("rst gnt", 32'(gnt), 0);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst done", 32'(done), 0);
        chk("rst mwren", 32'(mwren), 0);
        chk("rst maddr", 32'(maddr), 0);
        chk("rst mwdata", mwdata, 0);

        // Abort zero-fill part way and make sure it restarts from zero.
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("init500 maddr", 32'(maddr), 500);
        chk("init500 mwren", 32'(mwren), 1);
        chk("init500 mwdata", mwdata, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst maddr", 32'(maddr), 0);
        chk("midrst mwren", 32'(mwren), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst gnt", 32'(gnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("restart");

        // Request raised during init is served on the first ARB cycle.
        chk("pend gnt", 32'(gnt), 32'h1);
        chk("pend maddr", 32'(maddr), 32'h3FF);
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        chk("pend rvalid", 32'(rvalid), 32'h1);
        chk("rd 3FF zero", rdata, 0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            req = vt[i].req; wr = vt[i].wr;
            a0 = vt[i].a0;   a1 = vt[i].a1;
            d0 = vt[i].d0;   d1 = vt[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vt[i].rv));
            chk($sformatf("v%0d mwren", i), 32'(mwren), 32'(vt[i].wen));
            chk($sformatf("v%0d maddr", i), 32'(maddr), 32'(vt[i].ma));
            if (vt[i].rv != 2'b00)
                chk($sformatf("v%0d rdata", i), rdata, vt[i].rd);
            if (vt[i].wen)
                chk($sformatf("v%0d mwdata", i), mwdata, vt[i].wd);
        end

        // Both requesters read continuously: strict alternation, no gaps.
        prev = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            req = 2'b11; wr = 2'b00; a0 = 10'h010; a1 = 10'h011;
            @(negedge clk);
            chk($sformatf("alt%0d gnt", k), 32'(gnt),
                (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("alt%0d rvalid", k), 32'(rvalid), 32'(prev));
            prev = gnt;
        end
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        chk("alt tail rvalid", 32'(rvalid), 32'h1);

`ifdef SRAM_ARB_LOCK_EN
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            lock = 2'b01;
            wr   = 2'b00;
            req  = (k == 0) ? 2'b01 : (k < 4) ? 2'b11 : 2'b10;
            @(negedge clk);
            chk($sformatf("lock%0d gnt", k), 32'(gnt),
                (k < 4) ? 32'h1 : 32'h2);
        end
        @(posedge clk);
        #1;
        req  = 2'b00;
        lock = 2'b00;
`endif

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
